// File: rtl/pc_register_pkg.sv
// Shared LEGv8 program-counter definitions: address width, address type, increment and reset value.
package pc_register_pkg;
  localparam int ADDR_WIDTH = 12;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  localparam int PC_INC   = 4;
  localparam int PC_RESET = 0;
endpackage

// File: rtl/pc_register_incrementer.sv
// Sequential-address adder for the next-PC mux; result wraps modulo 2^WIDTH.
module pc_incrementer
  import pc_register_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH
) (
  input  logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_plus4
);
  assign inst_plus4 = inst + WIDTH'(PC_INC);
endmodule

// File: rtl/pc_register.sv
// LEGv8 program counter with load enable and async active-high reset.
// Optional PC_ALIGN_CHECK_EN adds a registered `misaligned` flag for loads with low bits set.
module pc_register
  import pc_register_pkg::*;
#(
  parameter int               WIDTH       = ADDR_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] new_inst,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_plus4
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misaligned
`endif
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst <= RESET_VALUE;
    end else if (en) begin
      inst <= new_inst;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Unaligned addresses are still loaded verbatim; the flag only reports them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned <= 1'b0;
    end else if (en) begin
      misaligned <= |new_inst[1:0];
    end
  end
`endif

  pc_incrementer #(.WIDTH(WIDTH)) u_inc (
    .inst       (inst),
    .inst_plus4 (inst_plus4)
  );

endmodule

// File: tb/tb_pc_register.sv
// Self-checking bench for pc_register; define PC_ALIGN_CHECK_EN to also exercise the misaligned flag.
module tb_pc_register;
  import pc_register_pkg::*;

  logic  clk = 1'b0;
  logic  reset = 1'b0;
  logic  en = 1'b0;
  addr_t new_inst = '0;
  addr_t inst;
  addr_t inst_plus4;
`ifdef PC_ALIGN_CHECK_EN
  logic  misaligned;
`endif

  int checks = 0;
  int errors = 0;
  addr_t exp_q[$];

  pc_register dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .new_inst   (new_inst),
    .inst       (inst),
    .inst_plus4 (inst_plus4)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misaligned (misaligned)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one load, then compare inst / inst_plus4 against the queued expectation.
  task automatic load_and_check(input addr_t v, input string name);
    addr_t exp;
    addr_t prev;
    prev = inst;
    new_inst = v;
    en = 1'b1;
    exp_q.push_back(v);
    #1;
    checks++;
    if (inst !== prev) begin
      errors++;
      $display("FAIL %s_latency: inst=%h before edge, required %h", name, inst, prev);
    end
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (inst !== exp) begin
      errors++;
      $display("FAIL %s_inst: got %h, required %h", name, inst, exp);
    end
    checks++;
    if (inst_plus4 !== addr_t'(exp + 12'd4)) begin
      errors++;
      $display("FAIL %s_plus4: got %h, required %h", name, inst_plus4, addr_t'(exp + 12'd4));
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (inst !== 12'h000) begin
      errors++;
      $display("FAIL reset_async_inst: got %h, required 000", inst);
    end
    checks++;
    if (inst_plus4 !== 12'h004) begin
      errors++;
      $display("FAIL reset_async_plus4: got %h, required 004", inst_plus4);
    end
`ifdef PC_ALIGN_CHECK_EN
    checks++;
    if (misaligned !== 1'b0) begin
      errors++;
      $display("FAIL reset_misaligned: got %b, required 0", misaligned);
    end
`endif
    new_inst = 12'hABC;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (inst !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold_%0d: got %h, required 000", i, inst);
      end
    end
    reset = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_load();
    load_and_check(12'b100010001000, "load0");
    load_and_check(12'b001001101000, "load1");
    load_and_check(12'b111111111000, "load2");
    load_and_check(12'b000000000000, "load3");
    load_and_check(12'b000111000000, "load4");
  endtask

  task automatic test_stall();
    load_and_check(12'h100, "stall_pre");
    en = 1'b0;
    new_inst = 12'h200;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (inst !== 12'h100) begin
        errors++;
        $display("FAIL stall_hold_%0d: got %h, required 100", i, inst);
      end
    end
    new_inst = 'x;
    tick();
    checks++;
    if (inst !== 12'h100) begin
      errors++;
      $display("FAIL stall_x_input: got %h, required 100", inst);
    end
    load_and_check(12'h200, "stall_resume");
  endtask

  task automatic test_wrap();
    load_and_check(12'hFFC, "wrap_ffc");
    checks++;
    if (inst_plus4 !== 12'h000) begin
      errors++;
      $display("FAIL wrap_ffc_abs: got %h, required 000", inst_plus4);
    end
    load_and_check(12'hFFE, "wrap_ffe");
    checks++;
    if (inst_plus4 !== 12'h002) begin
      errors++;
      $display("FAIL wrap_ffe_abs: got %h, required 002", inst_plus4);
    end
  endtask

  task automatic test_async_reset();
    load_and_check(12'h3A8, "async_pre");
    en = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (inst !== 12'h000) begin
      errors++;
      $display("FAIL async_mid_cycle: got %h, required 000", inst);
    end
    #1 reset = 1'b0;
    load_and_check(12'h044, "async_resume");
  endtask

  task automatic test_back_to_back();
    addr_t v;
    for (int i = 0; i < 8; i++) begin
      v = addr_t'($urandom_range(0, 4095));
      load_and_check(v, "b2b");
    end
  endtask

`ifdef PC_ALIGN_CHECK_EN
  task automatic test_align();
    load_and_check(12'h105, "align_105");
    checks++;
    if (misaligned !== 1'b1) begin
      errors++;
      $display("FAIL align_105_flag: got %b, required 1", misaligned);
    end
    load_and_check(12'h108, "align_108");
    checks++;
    if (misaligned !== 1'b0) begin
      errors++;
      $display("FAIL align_108_flag: got %b, required 0", misaligned);
    end
    load_and_check(12'h10A, "align_10a");
    en = 1'b0;
    new_inst = 12'h100;
    tick();
    checks++;
    if (misaligned !== 1'b1) begin
      errors++;
      $display("FAIL align_hold_flag: got %b, required 1", misaligned);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (misaligned !== 1'b0) begin
      errors++;
      $display("FAIL align_reset_flag: got %b, required 0", misaligned);
    end
    #1 reset = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_wrap();
    test_async_reset();
    test_back_to_back();
`ifdef PC_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
